// File: rtl/mem_scan_pkg.sv
// Shared types for the memory scan sequencer: FSM states, latched scan
// configuration and the default-stride helper.
package mem_scan_pkg;

   localparam int unsigned CFG_ADDR_W = 32;
   localparam int unsigned STRIDE_W   = 8;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      OUT
   } state_e;

   typedef struct packed {
      logic [CFG_ADDR_W-1:0] base;
      logic [CFG_ADDR_W-1:0] limit;
      logic [STRIDE_W-1:0]   stride;
      logic                  mode_wrap;
   } scan_cfg_t;

   // One data word per step when the requested stride is zero.
   function automatic logic [STRIDE_W-1:0] def_stride(input int unsigned data_w);
      return STRIDE_W'(data_w / 8);
   endfunction

endpackage

// File: rtl/scan_addr_gen.sv
// Current scan address register with next-address, carry and end-of-pass
// detection; wraps back to base when a pass completes.
module scan_addr_gen
   import mem_scan_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                load,
   input  logic                step,
   input  logic [ADDR_W-1:0]   load_addr,
   input  logic [ADDR_W-1:0]   base_addr,
   input  logic [ADDR_W-1:0]   limit_addr,
   input  logic [STRIDE_W-1:0] stride,
   output logic [ADDR_W-1:0]   cur_addr,
   output logic                last_in_pass_c
);

   localparam int unsigned NXT_W = ADDR_W + 1;

   logic [ADDR_W-1:0] cur_q, cur_d;
   logic [NXT_W-1:0]  nxt_c;

   // Extra top bit catches address-space overflow so we never wrap to 0.
   always_comb begin
      nxt_c          = {1'b0, cur_q} + NXT_W'(stride);
      last_in_pass_c = nxt_c[ADDR_W] | (nxt_c[ADDR_W-1:0] > limit_addr);
      cur_d          = cur_q;
      if (load) begin
         cur_d = load_addr;
      end else if (step) begin
         cur_d = last_in_pass_c ? base_addr : nxt_c[ADDR_W-1:0];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cur_q <= '0;
      end else begin
         cur_q <= cur_d;
      end
   end

   assign cur_addr = cur_q;

endmodule

// File: rtl/mem_scan_seq.sv
// DMA-style read scanner: sweeps base..limit by stride over a synchronous
// memory, streams each word out, and tracks checksum and completed passes.
module mem_scan_seq
   import mem_scan_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned MEM_LAT = 1,
   parameter int unsigned PASS_W  = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic                stop,
   input  logic                mode_wrap,
   input  logic [ADDR_W-1:0]   base_addr,
   input  logic [ADDR_W-1:0]   limit_addr,
   input  logic [STRIDE_W-1:0] stride,
   output logic [ADDR_W-1:0]   raddress,
   input  logic [DATA_W-1:0]   rdata,
   output logic [DATA_W-1:0]   out_data,
   output logic [ADDR_W-1:0]   out_addr,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                busy,
   output logic                done,
   output logic                aborted,
   output logic [DATA_W-1:0]   checksum,
   output logic [PASS_W-1:0]   pass_count
);

   localparam int unsigned LAT_W = 3;

   state_e              state_q, state_d;
   scan_cfg_t           cfg_q, cfg_d;
   logic [LAT_W-1:0]    lat_q, lat_d;
   logic [ADDR_W-1:0]   raddr_q, raddr_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
   logic                out_valid_q, out_valid_d;
   logic                done_q, done_d;
   logic                aborted_q, aborted_d;
   logic                busy_q, busy_d;
   logic [DATA_W-1:0]   checksum_q, checksum_d;
   logic [PASS_W-1:0]   pass_q, pass_d;

   logic                ag_load_c, ag_step_c, last_c, hs_c;
   logic [ADDR_W-1:0]   cur_addr;

   scan_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
      .clock          (clock),
      .reset          (reset),
      .load           (ag_load_c),
      .step           (ag_step_c),
      .load_addr      (base_addr),
      .base_addr      (ADDR_W'(cfg_q.base)),
      .limit_addr     (ADDR_W'(cfg_q.limit)),
      .stride         (cfg_q.stride),
      .cur_addr       (cur_addr),
      .last_in_pass_c (last_c)
   );

   always_comb begin
      state_d     = state_q;
      cfg_d       = cfg_q;
      lat_d       = lat_q;
      raddr_d     = raddr_q;
      out_data_d  = out_data_q;
      out_addr_d  = out_addr_q;
      out_valid_d = out_valid_q;
      done_d      = 1'b0;
      aborted_d   = 1'b0;
      checksum_d  = checksum_q;
      pass_d      = pass_q;
      ag_load_c   = 1'b0;
      ag_step_c   = 1'b0;
      hs_c        = out_valid_q & out_ready;

      case (state_q)
         IDLE: begin
            if (start) begin
               cfg_d.base      = CFG_ADDR_W'(base_addr);
               cfg_d.limit     = CFG_ADDR_W'(limit_addr);
               cfg_d.stride    = (stride == '0) ? def_stride(DATA_W) : stride;
               cfg_d.mode_wrap = mode_wrap;
               checksum_d      = '0;
               pass_d          = '0;
               if (limit_addr < base_addr) begin
                  done_d = 1'b1;
               end else begin
                  ag_load_c = 1'b1;
                  state_d   = ISSUE;
               end
            end
         end
         ISSUE: begin
            raddr_d = cur_addr;
            lat_d   = LAT_W'(MEM_LAT);
            state_d = WAIT;
         end
         WAIT: begin
            if (lat_q <= LAT_W'(1)) begin
               out_data_d  = rdata;
               out_addr_d  = cur_addr;
               out_valid_d = 1'b1;
               state_d     = OUT;
            end else begin
               lat_d = lat_q - LAT_W'(1);
            end
         end
         OUT: begin
            if (hs_c) begin
               checksum_d  = checksum_q + out_data_q;
               ag_step_c   = 1'b1;
               out_valid_d = 1'b0;
               state_d     = ISSUE;
               if (last_c) begin
                  pass_d = (&pass_q) ? pass_q : pass_q + PASS_W'(1);
                  if (!cfg_q.mode_wrap) begin
                     done_d  = 1'b1;
                     state_d = IDLE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Abort overrides everything except the checksum of a same-edge beat.
      if ((state_q != IDLE) && stop) begin
         state_d     = IDLE;
         out_valid_d = 1'b0;
         aborted_d   = 1'b1;
         done_d      = 1'b0;
         pass_d      = pass_q;
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cfg_q       <= '0;
         lat_q       <= '0;
         raddr_q     <= '0;
         out_data_q  <= '0;
         out_addr_q  <= '0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
         aborted_q   <= 1'b0;
         busy_q      <= 1'b0;
         checksum_q  <= '0;
         pass_q      <= '0;
      end else begin
         state_q     <= state_d;
         cfg_q       <= cfg_d;
         lat_q       <= lat_d;
         raddr_q     <= raddr_d;
         out_data_q  <= out_data_d;
         out_addr_q  <= out_addr_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
         aborted_q   <= aborted_d;
         busy_q      <= busy_d;
         checksum_q  <= checksum_d;
         pass_q      <= pass_d;
      end
   end

   assign raddress   = raddr_q;
   assign out_data   = out_data_q;
   assign out_addr   = out_addr_q;
   assign out_valid  = out_valid_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign aborted    = aborted_q;
   assign checksum   = checksum_q;
   assign pass_count = pass_q;

endmodule

// File: doc/mem_scan_seq.md
Name: mem_scan_seq

Overview:
- Parametrised read-address sequencer that sweeps a synchronous-read memory (Memoria32-class) from base to limit in steps of stride.
- Captures each read word and presents it on a valid/ready output stream.
- Keeps a running additive checksum and a pass counter.
- Supports one-shot and wrap-around modes and a start/stop/done handshake, so the UP datapath and benches can reuse it as a DMA-style scanner.

Parameters:
- ADDR_W, 32, width of address ports and address arithmetic.
- DATA_W, 32, width of memory data and checksum.
- MEM_LAT, 1, memory read latency in cycles (legal 1..4).
- PASS_W, 16, width of the pass counter.

Ports:
- clock  in  1  single system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  one-cycle pulse; begins a scan when IDLE; ignored otherwise.
- stop  in  1  abort request; honoured in any non-IDLE state.
- mode_wrap  in  1  0 = one-shot, 1 = wrap to base after limit; sampled at start.
- base_addr  in  ADDR_W  first address; sampled at start.
- limit_addr  in  ADDR_W  last address allowed (inclusive); sampled at start.
- stride  in  8  byte increment; 0 is treated as DATA_W/8; sampled at start.
- raddress  out  ADDR_W  registered memory read address.
- rdata  in  DATA_W  memory Dataout.
- out_data  out  DATA_W  captured word.
- out_addr  out  ADDR_W  address out_data was read from.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at normal completion (one-shot mode only).
- aborted  out  1  one-cycle pulse when stop ends a scan.
- checksum  out  DATA_W  sum mod 2^DATA_W of accepted out_data since the last start.
- pass_count  out  PASS_W  completed passes since the last start; saturates at all-ones.

Behaviour:
- Reset: all outputs, state and counters go to 0 and the FSM goes to IDLE. This applies mid-scan as well; any in-flight read is discarded.
- States:
  - IDLE: on start, latch config, clear checksum and pass_count, then go to ISSUE.
    - If limit_addr < base_addr (unsigned), pulse done with zero beats and stay in IDLE.
  - ISSUE: drive raddress = cur_addr, then go to WAIT with lat_cnt = MEM_LAT.
  - WAIT: decrement lat_cnt. On the MEM_LAT-th rising edge after raddress changed, register rdata into out_data and cur_addr into out_addr, set out_valid, and go to OUT.
  - OUT: hold out_valid, out_data and out_addr stable until out_valid && out_ready on a rising edge. On that handshake:
    - add out_data to checksum;
    - compute nxt = cur_addr + stride with ADDR_W+1 bits;
    - if carry = 0 and nxt <= limit: cur_addr = nxt, go to ISSUE;
    - else increment pass_count (saturating);
      - wrap mode: cur_addr = base, go to ISSUE;
      - one-shot mode: pulse done, go to IDLE.
- One read is outstanding at a time. Throughput is 1 beat per MEM_LAT+2 cycles when out_ready is held high.
- The limit address itself is read if it lies on the stride grid. Example: base 0, limit 64, stride 4 gives 17 beats (0..64), then wrap.
- stop: on the next rising edge go to IDLE, clear out_valid, pulse aborted, and do not pulse done. checksum and pass_count keep their values.
  - If stop and the handshake occur on the same edge, stop wins; the beat still counts toward checksum.
  - If stop and start occur together in IDLE, start is taken and stop is ignored.
- start while busy is ignored. out_valid never drops without a handshake except on stop or reset.
- raddress holds its last value while in IDLE.

Decomposition:
- Shared package mem_scan_pkg:
  - state enum {IDLE, ISSUE, WAIT, OUT};
  - constant DEF_STRIDE = DATA_W/8;
  - a config struct holding base, limit, stride and mode_wrap.
- One natural sub-module, scan_addr_gen: holds cur_addr, computes nxt/carry/wrap, and outputs a last_in_pass flag.
- The FSM, latency counter and output register stay in the top module.

Test Plan:
- Reset asserted mid-scan at cycle 7 -> raddress, out_valid, busy and checksum are 0 within the same time step; no done pulse.
- base 0, limit 64, stride 4, one-shot, ready = 1, mem[i] = i -> 17 beats with out_addr 0..64; done 1 cycle after the last handshake; checksum = 544; pass_count = 1.
- Same setup with mode_wrap = 1, run 40 beats -> out_addr sequence 0..64, 0..64, 0..20; pass_count = 2.
- stride 0, base 8, limit 20 -> addresses 8, 12, 16, 20; random out_ready backpressure keeps out_data and out_addr stable while stalled.
- base 0xFFFF_FFF8, limit 0xFFFF_FFFF, stride 8 -> one beat, carry detected, done; no wrap to address 0.
- stop during WAIT of the 3rd beat -> aborted pulse, IDLE, checksum = sum of the first 2 beats; a following start with limit 4 < base 8 -> immediate done, 0 beats.
